// File: rtl/data_memory.sv
// data_memory: word-organised synchronous data RAM, the responder on the core's
// data-memory port. One request at a time, WAIT_STATES wait cycles, then a
// one-cycle mem_ready pulse. Reads always return the full 32-bit word.
// Optional request checking (mem_err) is compiled in with DATA_MEMORY_ERR_EN.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic [3:0]  mem_w,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dw,
  output logic [31:0] mem_dr,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  generate
    if (WAIT_STATES > 15) begin : g_bad_wait
      $error("data_memory: WAIT_STATES must be in 0..15");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("data_memory: DEPTH_WORDS must be a power of two >= 2");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
      $error("data_memory: BASE_ADDR must be 4-byte aligned");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic            r_is_wr;
  logic [AW-1:0]   r_idx;
  logic [3:0]      r_mask;
  logic [31:0]     r_data;
  logic            r_err;
  logic [31:0]     r_dr;
  logic [31:0]     r_ram [DEPTH_WORDS];

  logic            w_req;
  logic            w_wr;
  logic            w_err;
  logic [31:0]     w_off;
  logic [AW-1:0]   w_idx;
  logic [AW-1:0]   w_op_idx;
  logic            w_op_rd;
  logic            w_op_err;

  assign w_wr  = |mem_w;
  assign w_req = mem_r | w_wr;
  assign w_off = mem_addr - BASE_ADDR;
  assign w_idx = AW'(w_off >> 2);

`ifdef DATA_MEMORY_ERR_EN
  logic [32:0] w_end;
  logic        w_range_err;
  logic        w_mask_err;

  assign w_end       = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
  assign w_range_err = (mem_addr < BASE_ADDR) || ({1'b0, mem_addr} >= w_end);

  // Only naturally aligned byte, halfword and word lane patterns are legal writes.
  always_comb begin
    w_mask_err = 1'b0;
    case (mem_w)
      4'b0000:                            w_mask_err = 1'b0;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_mask_err = 1'b0;
      4'b0011, 4'b1100:                   w_mask_err = mem_addr[0];
      4'b1111:                            w_mask_err = |mem_addr[1:0];
      default:                            w_mask_err = 1'b1;
    endcase
  end

  assign w_err = w_range_err | w_mask_err;
`else
  assign w_err = 1'b0;
`endif

  // The op entering RESP comes from the live request when leaving IDLE
  // directly (WAIT_STATES=0), otherwise from the latched copy.
  assign w_op_idx = (r_state == ST_IDLE) ? w_idx : r_idx;
  assign w_op_rd  = (r_state == ST_IDLE) ? !w_wr : !r_is_wr;
  assign w_op_err = (r_state == ST_IDLE) ? w_err : r_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: IDLE -> [WAIT x WAIT_STATES] -> RESP -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt <= 4'd1) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs: the ready/err pulse is suppressed while reset is asserted so an
  // aborted response never becomes visible.
  always_comb begin
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    if (r_state == ST_RESP && !rst) begin
      mem_ready = 1'b1;
`ifdef DATA_MEMORY_ERR_EN
      mem_err   = r_err;
`endif
    end
  end

  assign mem_dr = r_dr;

  // Request capture, wait counter and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_mask  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_dr    <= '0;
    end else begin
      if (r_state == ST_IDLE && w_req) begin
        r_is_wr <= w_wr;
        r_idx   <= w_idx;
        r_mask  <= mem_w;
        r_data  <= mem_dw;
        r_err   <= w_err;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == ST_WAIT) begin
        r_cnt   <= r_cnt - 4'd1;
      end
      if (w_next == ST_RESP && w_op_rd) begin
        r_dr <= w_op_err ? '0 : r_ram[w_op_idx];
      end
    end
  end

  // RAM write at the end of the RESP cycle, per enabled byte lane.
  always_ff @(posedge clk) begin
    if (!rst && r_state == ST_RESP && r_is_wr && !r_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_mask[i]) r_ram[r_idx][8*i +: 8] <= r_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: one instance with two wait states for
// the functional scenarios and randomized traffic, one with zero wait states
// for back-to-back throughput. Honours DATA_MEMORY_ERR_EN if defined.
`timescale 1ns/1ps
module tb_data_memory;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned WS_A  = 2;
  localparam int unsigned WS_B  = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_r, b_r;
  logic [3:0]  a_w, b_w;
  logic [31:0] a_addr, b_addr, a_dw, b_dw, a_dr, b_dr;
  logic        a_ready, b_ready, a_err, b_err;

  always #5 clk = ~clk;

  data_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS_A)) u_dut_a (
    .clk(clk), .rst(rst), .mem_r(a_r), .mem_w(a_w), .mem_addr(a_addr),
    .mem_dw(a_dw), .mem_dr(a_dr), .mem_ready(a_ready), .mem_err(a_err)
  );

  data_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS_B)) u_dut_b (
    .clk(clk), .rst(rst), .mem_r(b_r), .mem_w(b_w), .mem_addr(b_addr),
    .mem_dw(b_dw), .mem_dr(b_dr), .mem_ready(b_ready), .mem_err(b_err)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model of instance A: word array plus the last returned read data.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_dr;

  function automatic int unsigned ref_idx(input logic [31:0] addr);
    return ((addr - BASE) >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [3:0] mask,
                                            input logic [31:0] d);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) if (mask[i]) res[8*i +: 8] = d[8*i +: 8];
    return res;
  endfunction

`ifdef DATA_MEMORY_ERR_EN
  function automatic logic ref_err(input logic [3:0] w, input logic [31:0] addr);
    longint unsigned a, lo, hi;
    a  = longint'(addr);
    lo = longint'(BASE);
    hi = lo + 4 * longint'(DEPTH);
    if (a < lo || a >= hi) return 1'b1;
    if (w == 4'b0000) return 1'b0;
    if (!(w inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) return 1'b1;
    if (w == 4'b1111 && addr[1:0] != 2'b00) return 1'b1;
    if ((w == 4'b0011 || w == 4'b1100) && addr[0]) return 1'b1;
    return 1'b0;
  endfunction
`endif

  // Apply one request to the model; returns what instance A must answer.
  task automatic model_apply(input logic [3:0] w, input logic [31:0] addr, input logic [31:0] dw,
                             output logic [31:0] exp_dr, output logic exp_err);
    int unsigned idx;
    idx = ref_idx(addr);
`ifdef DATA_MEMORY_ERR_EN
    exp_err = ref_err(w, addr);
`else
    exp_err = 1'b0;
`endif
    if (w != 4'b0000) begin
      if (!exp_err) m_mem[idx] = ref_merge(m_mem[idx], w, dw);
    end else begin
      m_dr = exp_err ? 32'h0 : m_mem[idx];
    end
    exp_dr = m_dr;
  endtask

  // Drive one request (starting just after a rising edge, DUT idle), hold it
  // through the ready cycle, then drop it. lat = cycle index of mem_ready, -1 on timeout.
  task automatic xact(input bit sel_b, input logic r, input logic [3:0] w,
                      input logic [31:0] addr, input logic [31:0] dw,
                      output int lat, output logic [31:0] dr, output logic err);
    lat = -1;
    dr  = 'x;
    err = 1'bx;
    if (sel_b) begin b_r = r; b_w = w; b_addr = addr; b_dw = dw; end
    else       begin a_r = r; a_w = w; a_addr = addr; a_dw = dw; end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sel_b ? b_ready : a_ready) begin
        lat = c;
        dr  = sel_b ? b_dr : a_dr;
        err = sel_b ? b_err : a_err;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (sel_b) begin b_r = 1'b0; b_w = '0; end
    else       begin a_r = 1'b0; a_w = '0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_r = 1'b0; a_w = '0; a_addr = '0; a_dw = '0;
    b_r = 1'b0; b_w = '0; b_addr = '0; b_dw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", a_ready); end
    n_vec++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", a_err); end
    n_vec++; if (a_dr !== 32'h0) begin n_fail++; $display("FAIL reset_dr got=%h want=0", a_dr); end
    n_vec++; if (b_dr !== 32'h0) begin n_fail++; $display("FAIL reset_dr_b got=%h want=0", b_dr); end
    @(posedge clk);
    #1 rst = 1'b0;
    m_dr = 32'h0;
  endtask

  task automatic test_init();
    int lat; logic [31:0] dr, edr, d; logic err, eerr;
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      model_apply(4'b1111, BASE + 32'(4 * i), d, edr, eerr);
      xact(1'b0, 1'b0, 4'b1111, BASE + 32'(4 * i), d, lat, dr, err);
      n_vec++; if (lat !== int'(WS_A) + 1) begin n_fail++; $display("FAIL init_lat[%0d] got=%0d want=%0d", i, lat, WS_A + 1); end
    end
  endtask

  task automatic test_latency();
    int lat; logic [31:0] dr, edr; logic err, eerr;
    model_apply(4'b1111, 32'h10, 32'hDEADBEEF, edr, eerr);
    xact(1'b0, 1'b0, 4'b1111, 32'h10, 32'hDEADBEEF, lat, dr, err);
    n_vec++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got=%0d want=3", lat); end
    n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err got=%b want=0", err); end
    model_apply(4'b0000, 32'h10, 32'h0, edr, eerr);
    xact(1'b0, 1'b1, 4'b0000, 32'h10, 32'h0, lat, dr, err);
    n_vec++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency got=%0d want=3", lat); end
    n_vec++; if (dr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h want=deadbeef", dr); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] dr, edr; logic err, eerr;
    model_apply(4'b1111, 32'h20, 32'h11223344, edr, eerr);
    xact(1'b0, 1'b0, 4'b1111, 32'h20, 32'h11223344, lat, dr, err);
    model_apply(4'b0100, 32'h22, 32'h00AA0000, edr, eerr);
    xact(1'b0, 1'b0, 4'b0100, 32'h22, 32'h00AA0000, lat, dr, err);
    n_vec++; if (lat !== 3) begin n_fail++; $display("FAIL lane_wr_latency got=%0d want=3", lat); end
    model_apply(4'b0000, 32'h20, 32'h0, edr, eerr);
    xact(1'b0, 1'b1, 4'b0000, 32'h20, 32'h0, lat, dr, err);
    n_vec++; if (dr !== 32'h11AA3344) begin n_fail++; $display("FAIL lane_merge got=%h want=11aa3344", dr); end
  endtask

  task automatic test_write_wins();
    int lat; logic [31:0] dr, edr, prev; logic err, eerr;
    prev = m_dr;
    model_apply(4'b0011, 32'h30, 32'h0000BEEF, edr, eerr);
    xact(1'b0, 1'b1, 4'b0011, 32'h30, 32'h0000BEEF, lat, dr, err);
    n_vec++; if (dr !== prev) begin n_fail++; $display("FAIL wins_dr_hold got=%h want=%h", dr, prev); end
    n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL wins_err got=%b want=0", err); end
    model_apply(4'b0000, 32'h30, 32'h0, edr, eerr);
    xact(1'b0, 1'b1, 4'b0000, 32'h30, 32'h0, lat, dr, err);
    n_vec++; if (dr[15:0] !== 16'hBEEF) begin n_fail++; $display("FAIL wins_low got=%h want=beef", dr[15:0]); end
    n_vec++; if (dr !== edr) begin n_fail++; $display("FAIL wins_word got=%h want=%h", dr, edr); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] dr, edr, old; logic err, eerr; bit seen;
    model_apply(4'b1111, 32'h40, 32'h5A5A1234, edr, eerr);
    xact(1'b0, 1'b0, 4'b1111, 32'h40, 32'h5A5A1234, lat, dr, err);
    old = m_mem[ref_idx(32'h40)];
    a_r = 1'b0; a_w = 4'b1111; a_addr = 32'h40; a_dw = 32'hCAFEF00D;
    seen = 1'b0;
    @(negedge clk); seen |= a_ready;
    @(posedge clk); #1;
    rst = 1'b1; a_w = '0;
    @(negedge clk); seen |= a_ready;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(negedge clk); seen |= a_ready; end
    n_vec++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_ready got=%b want=0", seen); end
    n_vec++; if (a_dr !== 32'h0) begin n_fail++; $display("FAIL abort_dr got=%h want=0", a_dr); end
    m_dr = 32'h0;
    @(posedge clk); #1;
    model_apply(4'b0000, 32'h40, 32'h0, edr, eerr);
    xact(1'b0, 1'b1, 4'b0000, 32'h40, 32'h0, lat, dr, err);
    n_vec++; if (dr !== old) begin n_fail++; $display("FAIL abort_ram got=%h want=%h", dr, old); end
  endtask

  task automatic test_back_to_back();
    int lat, pulses; logic [31:0] dr, word; logic err;
    word = $urandom;
    xact(1'b1, 1'b0, 4'b1111, 32'h08, word, lat, dr, err);
    n_vec++; if (lat !== int'(WS_B) + 1) begin n_fail++; $display("FAIL b2b_wr_lat got=%0d want=1", lat); end
    pulses = 0;
    b_r = 1'b1; b_addr = 32'h08;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_vec++;
      if (b_ready !== ((c % 2) == 1)) begin
        n_fail++; $display("FAIL b2b_ready[%0d] got=%b want=%b", c, b_ready, (c % 2) == 1);
      end
      if (b_ready === 1'b1) begin
        pulses++;
        n_vec++; if (b_dr !== word) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h want=%h", c, b_dr, word); end
      end
    end
    @(posedge clk); #1;
    b_r = 1'b0;
    n_vec++; if (pulses !== 10) begin n_fail++; $display("FAIL b2b_pulses got=%0d want=10", pulses); end
  endtask

  task automatic test_err_boundary();
    int lat; logic [31:0] dr, edr, prev, eaddr; logic err, eerr;
    prev = m_dr;
    model_apply(4'b0101, 32'h50, 32'hA5A5A5A5, edr, eerr);
    xact(1'b0, 1'b0, 4'b0101, 32'h50, 32'hA5A5A5A5, lat, dr, err);
    n_vec++; if (lat !== 3) begin n_fail++; $display("FAIL mask_lat got=%0d want=3", lat); end
    n_vec++; if (err !== eerr) begin n_fail++; $display("FAIL mask_err got=%b want=%b", err, eerr); end
    n_vec++; if (dr !== prev) begin n_fail++; $display("FAIL mask_dr_hold got=%h want=%h", dr, prev); end
    model_apply(4'b0000, 32'h50, 32'h0, edr, eerr);
    xact(1'b0, 1'b1, 4'b0000, 32'h50, 32'h0, lat, dr, err);
    n_vec++; if (dr !== edr) begin n_fail++; $display("FAIL mask_ram got=%h want=%h", dr, edr); end
    eaddr = BASE + 32'(4 * DEPTH);
    model_apply(4'b0000, eaddr, 32'h0, edr, eerr);
    xact(1'b0, 1'b1, 4'b0000, eaddr, 32'h0, lat, dr, err);
    n_vec++; if (lat !== 3) begin n_fail++; $display("FAIL range_lat got=%0d want=3", lat); end
    n_vec++; if (err !== eerr) begin n_fail++; $display("FAIL range_err got=%b want=%b", err, eerr); end
    n_vec++; if (dr !== edr) begin n_fail++; $display("FAIL range_dr got=%h want=%h", dr, edr); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] dr, edr, addr, d; logic err, eerr, r; logic [3:0] w; int unsigned kind;
    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      addr = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) addr = addr + 32'(4 * DEPTH * $urandom_range(1, 3));
      kind = $urandom_range(0, 2);
      r = (kind != 1);
      w = (kind == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      d = $urandom;
      model_apply(w, addr, d, edr, eerr);
      xact(1'b0, r, w, addr, d, lat, dr, err);
      n_vec++; if (lat !== int'(WS_A) + 1) begin n_fail++; $display("FAIL rnd_lat[%0d] got=%0d want=%0d", t, lat, WS_A + 1); end
      n_vec++; if (err !== eerr) begin n_fail++; $display("FAIL rnd_err[%0d] got=%b want=%b", t, err, eerr); end
      n_vec++; if (dr !== edr) begin n_fail++; $display("FAIL rnd_dr[%0d] a=%h w=%b got=%h want=%h", t, addr, w, dr, edr); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_latency();
    test_byte_lanes();
    test_write_wins();
    test_reset_abort();
    test_back_to_back();
    test_err_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised synchronous data RAM; the responder on the core's data-memory port.
- Sits on the far side of the load/store memory controller.
- Accepts one read or byte-lane write request at a time, inserts programmable wait states, then completes it with a one-cycle ready pulse.
- Reads always return the full 32-bit word. Lane selection and sign extension stay in the controller.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; 4-byte aligned.
- WAIT_STATES, 1: extra cycles between acceptance and response; range 0..15.

Ports:
- clk  input  1  core clock; everything is sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_r  input  1  read request.
- mem_w  input  4  byte-lane write enables; bit i covers mem_dw[8i+7:8i].
- mem_addr  input  32  byte address.
- mem_dw  input  32  write data, already lane-aligned by the requester.
- mem_dr  output  32  read data; valid when mem_ready=1.
- mem_ready  output  1  one-cycle completion pulse.
- mem_err  output  1  request rejected; qualified by mem_ready.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, mem_dr=0, mem_ready=0, mem_err=0, wait counter=0. RAM contents are not reset.
- Request: a request is present when mem_r=1 or mem_w!=0. If both are set, the write wins and the read is ignored.
- Requester obligation: hold mem_r, mem_w, mem_addr and mem_dw stable from the request until the mem_ready cycle inclusive.
- Word index: ((mem_addr - BASE_ADDR) >> 2) modulo DEPTH_WORDS. mem_addr[1:0] is ignored for indexing.
- State IDLE:
  - mem_ready=0.
  - On a request, latch the op (read/write), index, lane mask and data.
  - Load the counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else to RESP.
- State WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 1.
  - Dwell in WAIT is exactly WAIT_STATES cycles.
- State RESP (lasts one cycle):
  - mem_ready=1.
  - Write: RAM lanes with mask bit set are updated at the end of this cycle; other lanes are untouched.
  - Read: mem_dr holds the word read from the latched index.
  - Next state is always IDLE.
- Latency: the request is sampled in cycle T; mem_ready=1 in cycle T+1+WAIT_STATES.
- Throughput:
  - At least one IDLE cycle between responses.
  - A request still asserted in the cycle after mem_ready is treated as a new request.
- mem_dr:
  - Updated only on read responses.
  - Holds its value across writes and idle cycles.
- Read-after-write to the same word (next request) returns the merged new data.
- Mask 4'b0000 with mem_r=0 is not a request.
- Reset mid-operation (in WAIT or RESP before the clock edge):
  - Operation aborted, no RAM update, no mem_ready pulse.
  - Outputs return to their reset values on the next cycle.
- Counter width: 4 bits; WAIT_STATES>15 is a parameter error (elaboration-time check).

Optional Feature:
- Macro: DATA_MEMORY_ERR_EN.
- With the macro, a request is flagged at acceptance if:
  - mem_addr < BASE_ADDR or mem_addr >= BASE_ADDR+4*DEPTH_WORDS, or
  - a write has a mask not in {0001, 0010, 0100, 1000, 0011, 1100, 1111}, or
  - a write has mask 1111 with mem_addr[1:0]!=0, or mask 0011/1100 with mem_addr[0]=1.
- A flagged request still takes the full latency. In RESP:
  - mem_ready=1, mem_err=1.
  - No RAM write.
  - A flagged read drives mem_dr=0.
- Without the macro:
  - mem_err is tied to 0.
  - Out-of-range addresses wrap modulo DEPTH_WORDS.
  - Any mask is applied as given.

Test Plan:
1. WAIT_STATES=2. Write mask 1111, addr 0x10, data 0xDEADBEEF in cycle 0. Then read 0x10 → mem_ready only in cycle 3 and again 3 cycles after the read is sampled; mem_dr=0xDEADBEEF.
2. Byte lanes. Write 0x11223344 with mask 1111 to 0x20. Then write mask 0100, addr 0x22, data 0x00AA0000. Read 0x20 → 0x11AA3344.
3. Simultaneous mem_r=1 and mem_w=0011 to 0x30, data 0x0000BEEF → treated as a write. mem_dr keeps its previous value. A later read of 0x30 shows low half 0xBEEF.
4. Reset asserted in WAIT during a write of 0xCAFEF00D to 0x40 → no mem_ready pulse. A subsequent read of 0x40 returns the old contents. mem_dr=0 after reset.
5. WAIT_STATES=0 back-to-back:
   - Reads held continuously → mem_ready pulses every second cycle with an IDLE cycle between.
   - No pulse is lost or duplicated.
6. DATA_MEMORY_ERR_EN defined. Write mask 0101 to 0x50, and read BASE_ADDR+4*DEPTH_WORDS → each gives mem_ready=1, mem_err=1; the read has mem_dr=0; RAM unchanged.
   - Without the macro, the same read returns the word at index 0.
